usb_ep_out_sink: RTL and testbench

- Bulk OUT endpoint receiver. Sits between the device controller's receive interface (rxact/rxval/rxdat/rxpktval/endpt, clocked by the 60 MHz PHY clock) and user logic.
- Buffers host-to-device packets for one endpoint in a byte FIFO. Commits a packet only when the controller flags it good, and rolls back bad packets.
- Drives rxrdy so the controller NAKs when a full max-size packet will not fit.
- Complement of the existing IN-direction data source.

---
 rtl/usb_ep_out_sink.sv | 256 +++++++++++++++++++++++++
 tb/tb_usb_ep_out_sink.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_ep_out_sink.sv
// usb_ep_out_sink: bulk OUT endpoint receiver that buffers host packets in a byte FIFO and commits or rolls back each one.
// Latency: the first byte of a committed packet appears on m_valid_o 2 clocks after the commit cycle
//          (3 clocks with USB_OUT_PKT_LAST_EN, because of the extra DRAIN cycle).
// Backpressure: m_ready_i stalls the output register. rxrdy_o drops while fewer than MAX_PKT bytes are free,
//               so the controller NAKs the host.
// Optional macro: USB_OUT_PKT_LAST_EN adds a 9th FIFO bit and the m_last_o output, which marks the last byte of a packet.
// Ports:
//   clk_i, reset_n_i                        : PHY clock and asynchronous active-low reset
//   endpt_i, rxact_i, rxval_i, rxdat_i,
//   rxpktval_i, rxrdy_o                     : device-controller receive interface
//   m_data_o, m_valid_o, m_ready_i
//   (m_last_o)                              : valid/ready byte stream to user logic
//   pkt_cnt_o, drop_cnt_o, ovf_o            : committed/dropped packet counters and sticky overflow flag
module usb_ep_out_sink #(
  parameter int ENDPT   = 2,
  parameter int DEPTH   = 1024,
  parameter int MAX_PKT = 512
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [3:0]  endpt_i,
  input  logic        rxact_i,
  input  logic        rxval_i,
  input  logic [7:0]  rxdat_i,
  input  logic        rxpktval_i,
  output logic        rxrdy_o,
  output logic [7:0]  m_data_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
`ifdef USB_OUT_PKT_LAST_EN
  output logic        m_last_o,
`endif
  output logic [15:0] pkt_cnt_o,
  output logic [7:0]  drop_cnt_o,
  output logic        ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;               // extra bit tells full from empty
  localparam int LW = $clog2(MAX_PKT + 1);
`ifdef USB_OUT_PKT_LAST_EN
  localparam int DW = 9;
`else
  localparam int DW = 8;
`endif
  localparam logic [PW:0]   DEPTH_W = (PW+1)'(DEPTH);
  localparam logic [PW:0]   MAX_W   = (PW+1)'(MAX_PKT);
  localparam logic [LW-1:0] MAX_L   = LW'(MAX_PKT);
  localparam logic [3:0]    ENDPT_W = 4'(ENDPT);

`ifdef USB_OUT_PKT_LAST_EN
  typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_e;
`else
  typedef enum logic [1:0] {IDLE, RECV} state_e;
`endif

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_spec_q, wr_spec_d, wr_com_q, wr_com_d, rd_q, rd_d;
  logic [LW-1:0]   len_q, len_d;
  logic            pkt_ok_q, pkt_ok_d, pkt_bad_q, pkt_bad_d;
  logic            rxrdy_q, rxrdy_d;
  logic            m_valid_q, m_valid_d;
  logic [7:0]      m_data_q, m_data_d;
  logic [15:0]     pkt_cnt_q, pkt_cnt_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic            ovf_q, ovf_d;
`ifdef USB_OUT_PKT_LAST_EN
  logic            m_last_q, m_last_d;
  logic [7:0]      last_dat_q, last_dat_d;
  logic [PW-1:0]   wr_last_w;
`endif

  logic [DW-1:0]   mem [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [DW-1:0]   mem_wdat;
  logic [DW-1:0]   rd_word;
  logic [PW-1:0]   used_q_w, used_w;
  logic [PW:0]     free_q_w, free_w;

  assign rd_word = mem[rd_q[AW-1:0]];

  // rxrdy_o looks only at the registered pointers, so it lags by one cycle.
  assign used_q_w = wr_spec_q - rd_q;
  assign free_q_w = DEPTH_W - {1'b0, used_q_w};
  assign rxrdy_d  = (free_q_w >= MAX_W);

  // The write-side space check counts this cycle's pop. With free==0 the write slot
  // equals the slot being read, but the read is combinational and sees the old byte.
  assign used_w = wr_spec_q - rd_d;
  assign free_w = DEPTH_W - {1'b0, used_w};

`ifdef USB_OUT_PKT_LAST_EN
  assign wr_last_w = wr_spec_q - PW'(1);
`endif

  // Read side: a single output register, refilled whenever it is empty or being consumed.
  always_comb begin
    rd_d      = rd_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
`ifdef USB_OUT_PKT_LAST_EN
    m_last_d  = m_last_q;
`endif
    if ((rd_q != wr_com_q) && (!m_valid_q || m_ready_i)) begin
      rd_d      = rd_q + PW'(1);
      m_valid_d = 1'b1;
      m_data_d  = rd_word[7:0];
`ifdef USB_OUT_PKT_LAST_EN
      m_last_d  = rd_word[8];
`endif
    end else if (m_ready_i) begin
      m_valid_d = 1'b0;
    end
  end

  // Write side and packet FSM.
  always_comb begin
    state_d    = state_q;
    wr_spec_d  = wr_spec_q;
    wr_com_d   = wr_com_q;
    len_d      = len_q;
    pkt_ok_d   = pkt_ok_q;
    pkt_bad_d  = pkt_bad_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    ovf_d      = ovf_q;
    mem_we     = 1'b0;
    mem_waddr  = wr_spec_q[AW-1:0];
`ifdef USB_OUT_PKT_LAST_EN
    mem_wdat   = {1'b0, rxdat_i};
    last_dat_d = last_dat_q;
`else
    mem_wdat   = rxdat_i;
`endif
    case (state_q)
      IDLE: begin
        if (rxact_i && (endpt_i == ENDPT_W)) begin
          state_d   = RECV;
          len_d     = '0;
          pkt_ok_d  = 1'b0;
          pkt_bad_d = 1'b0;
        end
      end
      RECV: begin
        if (rxact_i) begin
          if (rxval_i) begin
            if ((free_w != '0) && (len_q < MAX_L)) begin
              mem_we    = 1'b1;
              wr_spec_d = wr_spec_q + PW'(1);
              len_d     = len_q + LW'(1);
`ifdef USB_OUT_PKT_LAST_EN
              last_dat_d = rxdat_i;
`endif
            end else begin
              pkt_bad_d = 1'b1;
              ovf_d     = 1'b1;
            end
          end
          if (rxpktval_i) begin
            pkt_ok_d = 1'b1;
          end
        end else begin
          // A good-packet pulse arriving together with the falling rxact_i still counts.
          state_d = IDLE;
          if ((pkt_ok_q || rxpktval_i) && !pkt_bad_q) begin
`ifdef USB_OUT_PKT_LAST_EN
            if (len_q != '0) begin
              state_d = DRAIN;
            end else begin
              pkt_cnt_d = pkt_cnt_q + 16'd1;
            end
`else
            wr_com_d  = wr_spec_q;
            pkt_cnt_d = pkt_cnt_q + 16'd1;
`endif
          end else begin
            wr_spec_d = wr_com_q;
            if (drop_cnt_q != 8'hFF) begin
              drop_cnt_d = drop_cnt_q + 8'd1;
            end
          end
        end
      end
`ifdef USB_OUT_PKT_LAST_EN
      DRAIN: begin
        // Rewrite the final byte with its last flag before the packet becomes readable.
        mem_we    = 1'b1;
        mem_waddr = wr_last_w[AW-1:0];
        mem_wdat  = {1'b1, last_dat_q};
        wr_com_d  = wr_spec_q;
        pkt_cnt_d = pkt_cnt_q + 16'd1;
        state_d   = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdat;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      wr_spec_q  <= '0;
      wr_com_q   <= '0;
      rd_q       <= '0;
      len_q      <= '0;
      pkt_ok_q   <= 1'b0;
      pkt_bad_q  <= 1'b0;
      rxrdy_q    <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= 8'h00;
      pkt_cnt_q  <= 16'h0000;
      drop_cnt_q <= 8'h00;
      ovf_q      <= 1'b0;
`ifdef USB_OUT_PKT_LAST_EN
      m_last_q   <= 1'b0;
      last_dat_q <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      wr_spec_q  <= wr_spec_d;
      wr_com_q   <= wr_com_d;
      rd_q       <= rd_d;
      len_q      <= len_d;
      pkt_ok_q   <= pkt_ok_d;
      pkt_bad_q  <= pkt_bad_d;
      rxrdy_q    <= rxrdy_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ovf_q      <= ovf_d;
`ifdef USB_OUT_PKT_LAST_EN
      m_last_q   <= m_last_d;
      last_dat_q <= last_dat_d;
`endif
    end
  end

  assign rxrdy_o    = rxrdy_q;
  assign m_valid_o  = m_valid_q;
  assign m_data_o   = m_data_q;
  assign pkt_cnt_o  = pkt_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
  assign ovf_o      = ovf_q;
`ifdef USB_OUT_PKT_LAST_EN
  assign m_last_o   = m_last_q;
`endif

endmodule

// File: tb/tb_usb_ep_out_sink.sv
// Bench for usb_ep_out_sink: directed packet table, fill/overflow, reset mid-packet and random packets.
// The expected byte stream and counters come from a packet-level model (a byte queue plus counters).
// The output stream is checked beat by beat, including data hold during stalls.
module tb_usb_ep_out_sink;
  localparam int ENDPT   = 2;
  localparam int DEPTH   = 1024;
  localparam int MAX_PKT = 512;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [3:0]  endpt_i;
  logic        rxact_i, rxval_i, rxpktval_i;
  logic [7:0]  rxdat_i;
  logic        rxrdy_o;
  logic [7:0]  m_data_o;
  logic        m_valid_o;
  logic        m_ready_i;
`ifdef USB_OUT_PKT_LAST_EN
  logic        m_last_o;
`endif
  logic [15:0] pkt_cnt_o;
  logic [7:0]  drop_cnt_o;
  logic        ovf_o;

  usb_ep_out_sink #(.ENDPT(ENDPT), .DEPTH(DEPTH), .MAX_PKT(MAX_PKT)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .endpt_i(endpt_i), .rxact_i(rxact_i),
    .rxval_i(rxval_i), .rxdat_i(rxdat_i), .rxpktval_i(rxpktval_i), .rxrdy_o(rxrdy_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
`ifdef USB_OUT_PKT_LAST_EN
    .m_last_o(m_last_o),
`endif
    .pkt_cnt_o(pkt_cnt_o), .drop_cnt_o(drop_cnt_o), .ovf_o(ovf_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] ep;
    int         len;
    logic [7:0] base;
    logic [7:0] step;
    bit         crc;
    bit         late;
    int         exp_pkt;
    int         exp_drop;
    bit         exp_ovf;
  } vec_t;

  vec_t       vecs[7];
  logic [8:0] exp_q[$];     // {last, data} of committed bytes not yet consumed
  int         n_checks = 0;
  int         n_errs   = 0;
  int         n_pops   = 0;
  int         rmode    = 0; // 0: ready low, 1: ready high, 2: random
  int         mdl_pkt  = 0;
  int         mdl_drop = 0;
  bit         mdl_ovf  = 0;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mdl_pkt  = 0;
    mdl_drop = 0;
    mdl_ovf  = 0;
  endtask

  // Drives one OUT transaction, then updates the model from the packet rules:
  // accepted iff on our endpoint, good CRC, length <= MAX_PKT and it fits in the buffer.
  task automatic send_pkt(input logic [3:0] ep, input int len, input logic [7:0] base,
                          input logic [7:0] step, input bit crc, input bit late, input bit gaps);
    bit fits;
    fits = (exp_q.size() + len <= DEPTH);
    endpt_i = ep;
    rxact_i = 1'b1;
    cyc();
    for (int i = 0; i < len; i++) begin
      rxval_i = 1'b1;
      rxdat_i = base + 8'(i) * step;
      cyc();
      rxval_i = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) cyc();
    end
    if (crc && !late) begin
      rxpktval_i = 1'b1;
      cyc();
      rxpktval_i = 1'b0;
    end
    rxact_i    = 1'b0;
    rxpktval_i = crc && late;
    cyc();
    rxpktval_i = 1'b0;
    if (ep == 4'(ENDPT)) begin
      if (crc && len <= MAX_PKT && fits) begin
        mdl_pkt++;
        for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), base + 8'(i) * step});
      end else if (mdl_drop < 255) begin
        mdl_drop++;
      end
      if (len > MAX_PKT || !fits) mdl_ovf = 1;
    end
    cyc(); cyc(); cyc();
  endtask

  task automatic wait_drain(input int limit);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      cyc();
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errs++;
      $display("FAIL drain_timeout: %0d bytes outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_pkt_cnt"}, 32'(pkt_cnt_o), 32'(mdl_pkt));
    chk({tag, "_drop_cnt"}, 32'(drop_cnt_o), 32'(mdl_drop));
    chk({tag, "_ovf"}, 32'(ovf_o), 32'(mdl_ovf));
  endtask

  initial begin
    bit         stall_prev;
    logic [7:0] hold_dat;
    logic [8:0] e;
    int         p0, k;

    vecs[0] = '{4'd2, 4,   8'h11, 8'h11, 1'b1, 1'b0, 1, 0, 1'b0};
    vecs[1] = '{4'd2, 5,   8'h50, 8'h01, 1'b0, 1'b0, 1, 1, 1'b0};
    vecs[2] = '{4'd2, 2,   8'hAA, 8'h11, 1'b1, 1'b0, 2, 1, 1'b0};
    vecs[3] = '{4'd1, 3,   8'h70, 8'h01, 1'b1, 1'b0, 2, 1, 1'b0};
    vecs[4] = '{4'd2, 0,   8'h00, 8'h00, 1'b1, 1'b0, 3, 1, 1'b0};
    vecs[5] = '{4'd2, 512, 8'h00, 8'h01, 1'b1, 1'b0, 4, 1, 1'b0};
    vecs[6] = '{4'd2, 1,   8'h5A, 8'h00, 1'b1, 1'b1, 5, 1, 1'b0};

    reset_n_i = 1'b0; endpt_i = 4'd0; rxact_i = 1'b0; rxval_i = 1'b0;
    rxdat_i = 8'h00; rxpktval_i = 1'b0; m_ready_i = 1'b0;
    stall_prev = 1'b0; hold_dat = 8'h00;

    fork
      // Ready driver.
      forever begin
        @(posedge clk_i);
        #1;
        case (rmode)
          0:       m_ready_i = 1'b0;
          1:       m_ready_i = 1'b1;
          default: m_ready_i = 1'($urandom_range(0, 1));
        endcase
      end
      // Output monitor: at the falling edge, inputs and outputs are stable for the next active edge.
      forever begin
        @(negedge clk_i);
        if (reset_n_i) begin
          if (stall_prev) begin
            chk("hold_valid", 32'(m_valid_o), 32'd1);
            chk("hold_data", 32'(m_data_o), 32'(hold_dat));
          end
          if (m_valid_o && m_ready_i) begin
            n_pops++;
            n_checks++;
            if (exp_q.size() == 0) begin
              n_errs++;
              $display("FAIL unexpected_beat: got byte %0h, required no beat", m_data_o);
            end else begin
              e = exp_q.pop_front();
              if (m_data_o !== e[7:0]) begin
                n_errs++;
                $display("FAIL beat_data: got %0h expected %0h", m_data_o, e[7:0]);
              end
`ifdef USB_OUT_PKT_LAST_EN
              chk("beat_last", 32'(m_last_o), 32'(e[8]));
`endif
            end
          end
          stall_prev = m_valid_o && !m_ready_i;
          hold_dat   = m_data_o;
        end else begin
          stall_prev = 1'b0;
        end
      end
    join_none

    // Reset state and rxrdy_o rising on the first clock after release.
    cyc(); cyc(); cyc();
    chk("rst_rxrdy", 32'(rxrdy_o), 32'd0);
    chk("rst_valid", 32'(m_valid_o), 32'd0);
    chk("rst_data", 32'(m_data_o), 32'd0);
    chk_counters("rst");
    reset_n_i = 1'b1;
    #1;
    chk("rel_rxrdy_before_clk", 32'(rxrdy_o), 32'd0);
    cyc();
    chk("rel_rxrdy_first_clk", 32'(rxrdy_o), 32'd1);

    // Directed packet table.
    rmode = 1;
    for (int i = 0; i < 7; i++) begin
      send_pkt(vecs[i].ep, vecs[i].len, vecs[i].base, vecs[i].step, vecs[i].crc, vecs[i].late, 1'b0);
      wait_drain(2000);
      cyc(); cyc(); cyc();
      chk($sformatf("tbl%0d_valid_idle", i), 32'(m_valid_o), 32'd0);
      chk($sformatf("tbl%0d_pkt_cnt", i), 32'(pkt_cnt_o), 32'(vecs[i].exp_pkt));
      chk($sformatf("tbl%0d_drop_cnt", i), 32'(drop_cnt_o), 32'(vecs[i].exp_drop));
      chk($sformatf("tbl%0d_ovf", i), 32'(ovf_o), 32'(vecs[i].exp_ovf));
      chk($sformatf("tbl%0d_rxrdy", i), 32'(rxrdy_o), 32'd1);
    end

`ifdef USB_OUT_PKT_LAST_EN
    // Last-byte marking: 3-byte and 1-byte packets, then a zero-length packet.
    send_pkt(4'd2, 3, 8'h31, 8'h01, 1'b1, 1'b0, 1'b0);
    send_pkt(4'd2, 1, 8'h41, 8'h01, 1'b1, 1'b0, 1'b0);
    send_pkt(4'd2, 0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    wait_drain(200);
    cyc(); cyc(); cyc();
    chk("last_valid_idle", 32'(m_valid_o), 32'd0);
    chk_counters("last");
`endif

    // Fill with the consumer stalled.
    rmode = 0;
    cyc();
    send_pkt(4'd2, 512, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    chk("fill1_rxrdy", 32'(rxrdy_o), 32'd1);
    send_pkt(4'd2, 512, 8'h80, 8'h03, 1'b1, 1'b0, 1'b0);
    chk("fill2_rxrdy", 32'(rxrdy_o), 32'd0);
    chk("fill2_ovf", 32'(ovf_o), 32'd0);
    send_pkt(4'd2, 4, 8'hC0, 8'h01, 1'b1, 1'b0, 1'b0);
    chk_counters("fill3");
    chk("fill3_rxrdy", 32'(rxrdy_o), 32'd0);
    p0 = n_pops;
    k  = 0;
    rmode = 1;
    while (n_pops < p0 + 512 && k < 2000) begin
      cyc();
      k++;
    end
    rmode = 0;
    chk("pop512_done", 32'(n_pops >= p0 + 512), 32'd1);
    cyc(); cyc(); cyc();
    chk("pop512_rxrdy", 32'(rxrdy_o), 32'd1);
    rmode = 1;
    wait_drain(2000);

    // Reset in the middle of a 300-byte packet.
    endpt_i = 4'd2;
    rxact_i = 1'b1;
    cyc();
    for (int i = 0; i < 150; i++) begin
      rxval_i = 1'b1;
      rxdat_i = 8'(i);
      cyc();
    end
    reset_n_i = 1'b0;
    rxval_i   = 1'b0;
    rxact_i   = 1'b0;
    #1;
    model_reset();
    chk("midrst_rxrdy", 32'(rxrdy_o), 32'd0);
    chk("midrst_valid", 32'(m_valid_o), 32'd0);
    chk("midrst_data", 32'(m_data_o), 32'd0);
    chk_counters("midrst");
    cyc(); cyc();
    reset_n_i = 1'b1;
    cyc();
    chk("midrst_rel_rxrdy", 32'(rxrdy_o), 32'd1);
    send_pkt(4'd2, 8, 8'hE0, 8'h02, 1'b1, 1'b0, 1'b0);
    wait_drain(200);
    chk_counters("post_rst");

    // Random packets against the model, with a randomly stalling consumer.
    rmode = 2;
    for (int n = 0; n < 40; n++) begin
      logic [3:0] ep;
      int         len;
      k = 0;
      while (exp_q.size() >= 512 && k < 5000) begin
        cyc();
        k++;
      end
      ep  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd2;
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(513, 520)) : int'($urandom_range(0, 40));
      send_pkt(ep, len, 8'($urandom), 8'($urandom_range(1, 255)),
               ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)), 1'b1);
    end
    rmode = 1;
    wait_drain(5000);
    cyc(); cyc(); cyc();
    chk_counters("rand");
    chk("rand_valid_idle", 32'(m_valid_o), 32'd0);
    chk("rand_rxrdy", 32'(rxrdy_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
